// File: rtl/heavy_bucket_update_engine.sv
// ---------------------------------------------------------------------------
// heavy_bucket_update_engine
//
// Heavy-part bucket update stage of an Elastic sketch. Packets {key, value}
// are buffered in an input FIFO. Each packet then goes through a
// read / modify / write of one bucket in an external RAM that holds one
// bucket per address, using the vote+/vote- eviction rule. Flows that are
// displaced or rejected go to the light part. A flush sweeps the whole
// table, emits every live heavy record and clears each bucket.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   in_wr, in_data    push one {key, value} packet into the input FIFO
//   in_alf            FIFO at least half full
//   drop_cnt          pushes lost because the FIFO was full (saturating)
//   ram_rden/rdaddr   bucket read request; ram_rddata returns RD_LAT later
//   ram_wren/wraddr/
//   ram_wrdata        bucket write-back
//   out_wr, out_data  light-part record {key, count}; out_alf = sink almost full
//   flush_req         one-cycle flush request; flush_busy while sweeping
//   hv_wr, hv_data    heavy record {key, vote_pos} during flush;
//                     hv_alf = sink almost full
//   dbg_state_o       current FSM state, for observation only
//
// Handshake: every output strobe (ram_rden, ram_wren, out_wr, hv_wr) is a
// single-cycle valid with no ready. The sinks apply back-pressure only
// through the almost-full levels out_alf and hv_alf. These levels are
// looked at before new work is started and never in the middle of a
// transaction.
// ---------------------------------------------------------------------------
module heavy_bucket_update_engine #(
    parameter int KEY_W        = 32,
    parameter int VAL_W        = 32,
    parameter int CNT_W        = 32,
    parameter int ADDR_W       = 12,
    parameter int HASH_LSB     = 4,
    parameter int LAMBDA_SHIFT = 3,
    parameter int RD_LAT       = 2,
    parameter int FIFO_AW      = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_wr,
    input  logic [KEY_W+VAL_W-1:0]    in_data,
    output logic                      in_alf,
    output logic [31:0]               drop_cnt,
    output logic                      ram_rden,
    output logic [ADDR_W-1:0]         ram_rdaddr,
    input  logic [KEY_W+2*CNT_W-1:0]  ram_rddata,
    output logic                      ram_wren,
    output logic [ADDR_W-1:0]         ram_wraddr,
    output logic [KEY_W+2*CNT_W-1:0]  ram_wrdata,
    output logic                      out_wr,
    output logic [KEY_W+CNT_W-1:0]    out_data,
    input  logic                      out_alf,
    input  logic                      flush_req,
    output logic                      flush_busy,
    output logic                      hv_wr,
    output logic [KEY_W+CNT_W-1:0]    hv_data,
    input  logic                      hv_alf,
    output logic [2:0]                dbg_state_o
);

    localparam int B     = KEY_W + 2*CNT_W;
    localparam int PW    = KEY_W + VAL_W;
    localparam int CMP_W = CNT_W + LAMBDA_SHIFT + 1;
    localparam int WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] ALF_LVL  = {2'b01, {(FIFO_AW-1){1'b0}}};
    localparam logic [WC_W-1:0]  WAIT_END = WC_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WAIT   = 3'd2,
        S_UPD    = 3'd3,
        S_F_RD   = 3'd4,
        S_F_WAIT = 3'd5,
        S_F_UPD  = 3'd6
    } state_t;

    state_t state_q, state_d;

    // ---------------------------------------------------------------- FIFO
    logic [PW-1:0]      fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [31:0]        drop_cnt_q, drop_cnt_d;
    logic               fifo_full, fifo_empty, push_ok, pop;

    assign fifo_full  = (count_q == FULL_LVL);
    assign fifo_empty = (count_q == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign push_ok    = in_wr && (!fifo_full || pop);
    assign in_alf     = (count_q >= ALF_LVL);
    assign drop_cnt   = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        drop_cnt_d = drop_cnt_q;
        if (in_wr && fifo_full && !pop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------ control signals
    logic             can_issue, flush_go, flush_state, wait_last, last_addr;
    logic             flush_pend_q, flush_pend_d;
    logic [PW-1:0]    pkt_q;
    logic [B-1:0]     bkt_q;
    logic [ADDR_W-1:0] faddr_q;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;

    // UPD makes the same decision as IDLE so that a packet issues every
    // RD_LAT+2 cycles. A pending flush takes priority over new packets.
    assign can_issue   = (state_q == S_IDLE) || (state_q == S_UPD);
    assign flush_go    = can_issue && (flush_pend_q || flush_req);
    assign pop         = can_issue && !(flush_pend_q || flush_req) &&
                         !fifo_empty && !out_alf;
    assign flush_state = (state_q == S_F_RD) || (state_q == S_F_WAIT) ||
                         (state_q == S_F_UPD);
    assign wait_last   = (wait_cnt_q == WAIT_END);
    assign last_addr   = (faddr_q == '1);

    // A request that arrives while a sweep is already running is ignored.
    // The running sweep clears the table anyway.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (flush_go) begin
            flush_pend_d = 1'b0;
        end else if (flush_req && !flush_state) begin
            flush_pend_d = 1'b1;
        end
    end

    assign wait_cnt_d = ((state_q == S_WAIT) || (state_q == S_F_WAIT)) ?
                        wait_cnt_q + 1'b1 : '0;

    // ------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------- datapath regs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            pkt_q        <= '0;
            bkt_q        <= '0;
            faddr_q      <= '0;
            wait_cnt_q   <= '0;
        end else begin
            count_q      <= count_d;
            drop_cnt_q   <= drop_cnt_d;
            flush_pend_q <= flush_pend_d;
            wait_cnt_q   <= wait_cnt_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                pkt_q    <= fifo_mem[rd_ptr_q];
            end
            // The last WAIT cycle is exactly RD_LAT cycles after the read strobe.
            if (((state_q == S_WAIT) || (state_q == S_F_WAIT)) && wait_last) begin
                bkt_q <= ram_rddata;
            end
            if (flush_go) begin
                faddr_q <= '0;
            end else if (state_q == S_F_UPD) begin
                faddr_q <= faddr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_UPD: begin
                if (flush_go) begin
                    state_d = S_F_RD;
                end else if (pop) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD:     state_d = S_WAIT;
            S_WAIT:   if (wait_last) state_d = S_UPD;
            S_F_RD:   if (!hv_alf) state_d = S_F_WAIT;
            S_F_WAIT: if (wait_last) state_d = S_F_UPD;
            S_F_UPD:  state_d = last_addr ? S_IDLE : S_F_RD;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ update datapath
    logic [KEY_W-1:0]  pk_key, bk_key;
    logic [CNT_W-1:0]  v_ext, bk_pos, bk_neg, pos_sat, neg_sat;
    logic [CNT_W:0]    pos_sum, neg_sum;
    logic [CMP_W-1:0]  vote_neg_sum, vote_pos_scaled;
    logic [ADDR_W-1:0] pkt_addr;
    logic              bkt_empty, key_hit, evict;

    assign pk_key   = pkt_q[PW-1 -: KEY_W];
    assign v_ext    = CNT_W'(pkt_q[VAL_W-1:0]);
    assign bk_key   = bkt_q[B-1 -: KEY_W];
    assign bk_pos   = bkt_q[2*CNT_W-1 -: CNT_W];
    assign bk_neg   = bkt_q[CNT_W-1:0];
    assign pkt_addr = pk_key[HASH_LSB+ADDR_W-1:HASH_LSB];

    assign bkt_empty = (bkt_q == '0);
    assign key_hit   = (bk_key == pk_key);

    // The carry bit of each sum tells whether the counter must clamp.
    assign pos_sum = {1'b0, bk_pos} + {1'b0, v_ext};
    assign neg_sum = {1'b0, bk_neg} + {1'b0, v_ext};
    assign pos_sat = pos_sum[CNT_W] ? '1 : pos_sum[CNT_W-1:0];
    assign neg_sat = neg_sum[CNT_W] ? '1 : neg_sum[CNT_W-1:0];

    // Both sides are widened so that neither the sum nor the shift can wrap.
    assign vote_neg_sum    = CMP_W'(bk_neg) + CMP_W'(v_ext);
    assign vote_pos_scaled = CMP_W'(bk_pos) << LAMBDA_SHIFT;
    assign evict           = (vote_neg_sum >= vote_pos_scaled);

    // ------------------------------------------------------- output logic
    always_comb begin
        ram_rden   = 1'b0;
        ram_rdaddr = '0;
        ram_wren   = 1'b0;
        ram_wraddr = '0;
        ram_wrdata = '0;
        out_wr     = 1'b0;
        out_data   = '0;
        hv_wr      = 1'b0;
        hv_data    = '0;
        flush_busy = flush_state;
        case (state_q)
            S_RD: begin
                ram_rden   = 1'b1;
                ram_rdaddr = pkt_addr;
            end
            S_UPD: begin
                ram_wren   = 1'b1;
                ram_wraddr = pkt_addr;
                if (bkt_empty || key_hit) begin
                    ram_wrdata = {pk_key, pos_sat, bk_neg};
                end else if (evict) begin
                    ram_wrdata = {pk_key, v_ext, {CNT_W{1'b0}}};
                    out_wr     = 1'b1;
                    out_data   = {bk_key, bk_pos};
                end else begin
                    ram_wrdata = {bk_key, bk_pos, neg_sat};
                    out_wr     = 1'b1;
                    out_data   = {pk_key, v_ext};
                end
            end
            S_F_RD: begin
                // Holding off the read while hv_alf is high stalls the sweep
                // before it starts a new address.
                ram_rden   = !hv_alf;
                ram_rdaddr = faddr_q;
            end
            S_F_UPD: begin
                ram_wren   = 1'b1;
                ram_wraddr = faddr_q;
                hv_wr      = !bkt_empty;
                hv_data    = bkt_empty ? '0 : {bk_key, bk_pos};
            end
            default: begin
            end
        endcase
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_heavy_bucket_update_engine.sv
module tb_heavy_bucket_update_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_clr = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------- main DUT
  logic        m_in_wr = 1'b0;
  logic [63:0] m_in_data = '0;
  logic        m_in_alf;
  logic [31:0] m_drop_cnt;
  logic        m_ram_rden, m_ram_wren;
  logic [11:0] m_ram_rdaddr, m_ram_wraddr;
  logic [95:0] m_ram_rddata, m_ram_wrdata;
  logic        m_out_wr, m_out_alf = 1'b0;
  logic [63:0] m_out_data, m_hv_data;
  logic        m_flush_req = 1'b0, m_flush_busy, m_hv_wr, m_hv_alf = 1'b0;
  logic [2:0]  m_dbg;

  heavy_bucket_update_engine dut (
    .clk(clk), .reset(reset), .in_wr(m_in_wr), .in_data(m_in_data),
    .in_alf(m_in_alf), .drop_cnt(m_drop_cnt), .ram_rden(m_ram_rden),
    .ram_rdaddr(m_ram_rdaddr), .ram_rddata(m_ram_rddata), .ram_wren(m_ram_wren),
    .ram_wraddr(m_ram_wraddr), .ram_wrdata(m_ram_wrdata), .out_wr(m_out_wr),
    .out_data(m_out_data), .out_alf(m_out_alf), .flush_req(m_flush_req),
    .flush_busy(m_flush_busy), .hv_wr(m_hv_wr), .hv_data(m_hv_data),
    .hv_alf(m_hv_alf), .dbg_state_o(m_dbg)
  );

  // ---------------------------------------------------------- small DUT
  logic        s_in_wr = 1'b0;
  logic [63:0] s_in_data = '0;
  logic        s_in_alf;
  logic [31:0] s_drop_cnt;
  logic        s_ram_rden, s_ram_wren;
  logic [2:0]  s_ram_rdaddr, s_ram_wraddr;
  logic [95:0] s_ram_rddata, s_ram_wrdata;
  logic        s_out_wr;
  logic [63:0] s_out_data, s_hv_data;
  logic        s_flush_req = 1'b0, s_flush_busy, s_hv_wr, s_hv_alf = 1'b0;
  logic [2:0]  s_dbg;

  heavy_bucket_update_engine #(.ADDR_W(3), .FIFO_AW(4)) dut_s (
    .clk(clk), .reset(reset), .in_wr(s_in_wr), .in_data(s_in_data),
    .in_alf(s_in_alf), .drop_cnt(s_drop_cnt), .ram_rden(s_ram_rden),
    .ram_rdaddr(s_ram_rdaddr), .ram_rddata(s_ram_rddata), .ram_wren(s_ram_wren),
    .ram_wraddr(s_ram_wraddr), .ram_wrdata(s_ram_wrdata), .out_wr(s_out_wr),
    .out_data(s_out_data), .out_alf(1'b0), .flush_req(s_flush_req),
    .flush_busy(s_flush_busy), .hv_wr(s_hv_wr), .hv_data(s_hv_data),
    .hv_alf(s_hv_alf), .dbg_state_o(s_dbg)
  );

  // ------------------------------------------------ RAM models (latency 2)
  logic [95:0] m_mem [4096];
  logic [95:0] m_p1 = '0;
  logic        m_pl_en = 1'b0;
  logic [11:0] m_pl_addr = '0;
  logic [95:0] m_pl_data = '0;
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 4096; i++) m_mem[i] <= '0;
    if (m_ram_wren) m_mem[m_ram_wraddr] <= m_ram_wrdata;
    if (m_pl_en) m_mem[m_pl_addr] <= m_pl_data;
    if (m_ram_rden) m_p1 <= m_mem[m_ram_rdaddr];
    m_ram_rddata <= m_p1;
  end

  logic [95:0] s_mem [8];
  logic [95:0] s_p1 = '0;
  logic        s_pl_en = 1'b0;
  logic [2:0]  s_pl_addr = '0;
  logic [95:0] s_pl_data = '0;
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 8; i++) s_mem[i] <= '0;
    if (s_ram_wren) s_mem[s_ram_wraddr] <= s_ram_wrdata;
    if (s_pl_en) s_mem[s_pl_addr] <= s_pl_data;
    if (s_ram_rden) s_p1 <= s_mem[s_ram_rdaddr];
    s_ram_rddata <= s_p1;
  end

  // --------------------------------------------------------- checking
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the table as an array, updated from the rules directly.
  logic [95:0] model_tab [4096];
  logic [63:0] exp_q[$];
  bit          sb_on = 1'b0;

  function automatic void ref_update(input logic [95:0] b, input logic [63:0] pk,
                                     output logic [95:0] nb, output bit ow,
                                     output logic [63:0] od);
    longint unsigned k, p, n, key, v, lim, s;
    lim = 64'hFFFF_FFFF;
    k = b[95:64]; p = b[63:32]; n = b[31:0];
    key = pk[63:32]; v = pk[31:0];
    ow = 1'b0; od = '0;
    if (b == '0 || k == key) begin
      s = (p + v > lim) ? lim : p + v;
      nb = {pk[63:32], s[31:0], b[31:0]};
    end else if (n + v >= p * 8) begin
      nb = {pk[63:32], pk[31:0], 32'd0};
      ow = 1'b1; od = b[95:32];
    end else begin
      s = (n + v > lim) ? lim : n + v;
      nb = {b[95:32], s[31:0]};
      ow = 1'b1; od = pk;
    end
  endfunction

  int          m_rd_cnt = 0, m_wr_cnt = 0, m_last_rd_cyc = 0, m_last_wr_cyc = 0;
  logic [11:0] m_last_rdaddr, m_last_wraddr;
  logic [95:0] m_last_wrdata;
  logic        m_last_ow;
  logic [63:0] m_last_od;

  always @(negedge clk) begin
    logic [63:0] pk;
    logic [95:0] nb;
    logic [63:0] od;
    bit          ow;
    int          a;
    if (m_ram_rden) begin
      m_rd_cnt++; m_last_rd_cyc = cyc; m_last_rdaddr = m_ram_rdaddr;
    end
    if (m_out_wr && !m_ram_wren) chk("out_wr_without_write", 1'b1, 1'b0);
    if (m_ram_wren) begin
      m_wr_cnt++; m_last_wr_cyc = cyc; m_last_wraddr = m_ram_wraddr;
      m_last_wrdata = m_ram_wrdata; m_last_ow = m_out_wr; m_last_od = m_out_data;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 1'b1, 1'b0);
        end else begin
          pk = exp_q.pop_front();
          a = int'((pk[63:32] >> 4) % 4096);
          ref_update(model_tab[a], pk, nb, ow, od);
          model_tab[a] = nb;
          chk("sb_addr", m_ram_wraddr, a[11:0]);
          chk("sb_wrdata", m_ram_wrdata, nb);
          chk("sb_out_wr", m_out_wr, ow);
          if (ow) chk("sb_out_data", m_out_data, od);
        end
      end
    end
  end

  logic [2:0]  s_wa_q[$];
  logic [95:0] s_wd_q[$];
  logic [63:0] s_hv_q[$];
  logic [2:0]  s_hva_q[$];
  int          s_busy_cnt = 0, s_viol = 0;
  always @(negedge clk) begin
    if (s_ram_wren) begin s_wa_q.push_back(s_ram_wraddr); s_wd_q.push_back(s_ram_wrdata); end
    if (s_hv_wr) begin s_hv_q.push_back(s_hv_data); s_hva_q.push_back(s_ram_wraddr); end
    if (s_flush_busy) s_busy_cnt++;
    if (s_hv_alf && s_ram_rden) s_viol++;
  end

  // --------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic m_push(input logic [31:0] key, input logic [31:0] val);
    tick(); m_in_data = {key, val}; m_in_wr = 1'b1;
    tick(); m_in_wr = 1'b0;
  endtask

  task automatic s_push(input logic [31:0] key, input logic [31:0] val);
    tick(); s_in_data = {key, val}; s_in_wr = 1'b1;
    tick(); s_in_wr = 1'b0;
  endtask

  task automatic m_preload(input logic [11:0] a, input logic [95:0] d);
    tick(); m_pl_en = 1'b1; m_pl_addr = a; m_pl_data = d;
    tick(); m_pl_en = 1'b0;
  endtask

  task automatic s_preload(input logic [2:0] a, input logic [95:0] d);
    tick(); s_pl_en = 1'b1; s_pl_addr = a; s_pl_data = d;
    tick(); s_pl_en = 1'b0;
  endtask

  task automatic wait_m_write(input int n0, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (m_wr_cnt != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_s_flush_done(output bit ok);
    bit seen;
    seen = 1'b0; ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (s_flush_busy) seen = 1'b1;
      if (seen && !s_flush_busy) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [63:0] rand_pkt();
    logic [31:0] k, v;
    k = (32'($urandom_range(1, 4)) << 24) | (32'($urandom_range(0, 3)) << 4) |
        32'($urandom_range(0, 15));
    v = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(1, 200));
    return {k, v};
  endfunction

  // --------------------------------------------------------- vectors
  typedef struct {
    logic        preload;
    logic [95:0] pl_word;
    logic [31:0] key;
    logic [31:0] val;
    logic [11:0] exp_addr;
    logic [95:0] exp_wr;
    logic        exp_ow;
    logic [63:0] exp_od;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int n0, rd0;
    logic [63:0] pk;

    vecs[0] = '{1'b0, 96'h0, 32'h0A000010, 32'd5, 12'h001,
                {32'h0A000010, 32'd5, 32'd0}, 1'b0, 64'h0};
    vecs[1] = '{1'b0, 96'h0, 32'h0A000010, 32'd7, 12'h001,
                {32'h0A000010, 32'd12, 32'd0}, 1'b0, 64'h0};
    vecs[2] = '{1'b0, 96'h0, 32'h0B000010, 32'd10, 12'h001,
                {32'h0A000010, 32'd12, 32'd10}, 1'b1, {32'h0B000010, 32'd10}};
    vecs[3] = '{1'b0, 96'h0, 32'h0B000010, 32'd90, 12'h001,
                {32'h0B000010, 32'd90, 32'd0}, 1'b1, {32'h0A000010, 32'd12}};
    vecs[4] = '{1'b1, {32'h0C000020, 32'hFFFFFFF0, 32'd0}, 32'h0C000020, 32'h20, 12'h002,
                {32'h0C000020, 32'hFFFFFFFF, 32'd0}, 1'b0, 64'h0};

    // Reset
    repeat (4) @(posedge clk);
    #1 reset = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_rden", m_ram_rden, 1'b0);
    chk("rst_wren", m_ram_wren, 1'b0);
    chk("rst_out_wr", m_out_wr, 1'b0);
    chk("rst_hv_wr", m_hv_wr, 1'b0);
    chk("rst_busy", m_flush_busy, 1'b0);
    chk("rst_drop", m_drop_cnt, 32'd0);
    chk("rst_in_alf", m_in_alf, 1'b0);
    chk("rst_s_busy", s_flush_busy, 1'b0);

    // Directed update vectors
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].preload) m_preload(vecs[i].exp_addr, vecs[i].pl_word);
      n0 = m_wr_cnt;
      m_push(vecs[i].key, vecs[i].val);
      wait_m_write(n0, ok);
      chk($sformatf("v%0d_write_seen", i), ok, 1'b1);
      if (ok) begin
        chk($sformatf("v%0d_rdaddr", i), m_last_rdaddr, vecs[i].exp_addr);
        chk($sformatf("v%0d_wraddr", i), m_last_wraddr, vecs[i].exp_addr);
        chk($sformatf("v%0d_wrdata", i), m_last_wrdata, vecs[i].exp_wr);
        chk($sformatf("v%0d_out_wr", i), m_last_ow, vecs[i].exp_ow);
        if (vecs[i].exp_ow) chk($sformatf("v%0d_out_data", i), m_last_od, vecs[i].exp_od);
        chk($sformatf("v%0d_latency", i), m_last_wr_cyc - m_last_rd_cyc, 3);
      end
    end

    // Hand the current table to the reference model and enable the scoreboard.
    repeat (4) tick();
    for (int i = 0; i < 4096; i++) model_tab[i] = m_mem[i];
    sb_on = 1'b1;

    // Flood with out_alf held: nothing may be read; pushes 513..600 are dropped.
    rd0 = m_rd_cnt;
    tick();
    m_out_alf = 1'b1;
    for (int i = 0; i < 600; i++) begin
      pk = rand_pkt();
      m_in_data = pk; m_in_wr = 1'b1;
      if (i < 512) exp_q.push_back(pk);
      tick();
    end
    m_in_wr = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("flood_drop_cnt", m_drop_cnt, 32'd88);
    chk("flood_in_alf", m_in_alf, 1'b1);
    chk("flood_no_rden", m_rd_cnt - rd0, 0);
    tick();
    m_out_alf = 1'b0;
    wait_drain(3000, ok);
    chk("flood_drained", ok, 1'b1);
    repeat (4) tick();
    chk("flood_reads", m_rd_cnt - rd0, 512);
    chk("flood_in_alf_low", m_in_alf, 1'b0);

    // Random traffic with intermittent out_alf.
    for (int i = 0; i < 400; i++) begin
      m_out_alf = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        pk = rand_pkt();
        m_in_data = pk; m_in_wr = 1'b1;
        exp_q.push_back(pk);
      end else begin
        m_in_wr = 1'b0;
      end
      tick();
    end
    m_in_wr = 1'b0; m_out_alf = 1'b0;
    wait_drain(3000, ok);
    chk("rand_drained", ok, 1'b1);
    chk("rand_drop_cnt", m_drop_cnt, 32'd88);
    sb_on = 1'b0;

    // Small table flush, requested while a packet is in flight.
    s_preload(3'd5, {32'h0D000050, 32'h33, 32'h4});
    s_wa_q.delete(); s_wd_q.delete(); s_hv_q.delete(); s_hva_q.delete();
    s_busy_cnt = 0;
    s_push(32'h0A000010, 32'd5);
    tick(); tick();
    s_flush_req = 1'b1;
    tick();
    s_flush_req = 1'b0;
    wait_s_flush_done(ok);
    chk("f1_done", ok, 1'b1);
    chk("f1_busy_cycles", s_busy_cnt, 32);
    chk("f1_n_writes", s_wa_q.size(), 9);
    chk("f1_n_hv", s_hv_q.size(), 2);
    if (s_wa_q.size() == 9) begin
      chk("f1_pkt_addr", s_wa_q[0], 3'd1);
      chk("f1_pkt_data", s_wd_q[0], {32'h0A000010, 32'd5, 32'd0});
      for (int a = 0; a < 8; a++) begin
        chk($sformatf("f1_clr_addr%0d", a), s_wa_q[a+1], a[2:0]);
        chk($sformatf("f1_clr_data%0d", a), s_wd_q[a+1], 96'h0);
      end
    end
    if (s_hv_q.size() == 2) begin
      chk("f1_hv0", {s_hva_q[0], s_hv_q[0]}, {3'd1, 32'h0A000010, 32'd5});
      chk("f1_hv1", {s_hva_q[1], s_hv_q[1]}, {3'd5, 32'h0D000050, 32'h33});
    end

    // Second flush with hv_alf raised mid-sweep.
    s_preload(3'd1, {32'h0E000010, 32'h77, 32'h1});
    s_preload(3'd5, {32'h0F000050, 32'h88, 32'h0});
    s_wa_q.delete(); s_wd_q.delete(); s_hv_q.delete(); s_hva_q.delete();
    s_busy_cnt = 0; s_viol = 0;
    tick();
    s_flush_req = 1'b1;
    tick();
    s_flush_req = 1'b0;
    repeat (9) tick();
    s_hv_alf = 1'b1;
    repeat (12) tick();
    s_hv_alf = 1'b0;
    wait_s_flush_done(ok);
    chk("f2_done", ok, 1'b1);
    chk("f2_no_rden_in_stall", s_viol, 0);
    chk("f2_busy_stretched", (s_busy_cnt > 32) && (s_busy_cnt <= 44), 1'b1);
    chk("f2_n_writes", s_wa_q.size(), 8);
    if (s_hv_q.size() == 2) begin
      chk("f2_hv0", {s_hva_q[0], s_hv_q[0]}, {3'd1, 32'h0E000010, 32'h77});
      chk("f2_hv1", {s_hva_q[1], s_hv_q[1]}, {3'd5, 32'h0F000050, 32'h88});
    end else begin
      chk("f2_n_hv", s_hv_q.size(), 2);
    end
    for (int a = 0; a < 8; a++) chk($sformatf("f2_table_clear%0d", a), s_mem[a], 96'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
